// File: rtl/seg_scan_serial_if.sv
// seg_scan_serial_if: digit/control inputs and serial display outputs of the scanner
interface seg_scan_serial_if #(
    parameter int NDIG = 4
);
    logic [4*NDIG-1:0] digits;
    logic [NDIG-1:0]   dp_mask;
    logic              hex_en;
    logic              lz_blank;
    logic              sclk;
    logic              sdata;
    logic              latch;
    logic [NDIG-1:0]   dig_sel;
    logic              frame_done;
    modport master (output digits, dp_mask, hex_en, lz_blank, input sclk, sdata, latch, dig_sel, frame_done);
    modport slave (input digits, dp_mask, hex_en, lz_blank, output sclk, sdata, latch, dig_sel, frame_done);
endinterface

// File: rtl/seg_scan_serial.sv
// seg_scan_serial: multiplexed 7-segment scanner feeding an external 8-bit shift register
module seg_scan_serial #(
    parameter int NDIG     = 4,
    parameter int DIV      = 2,
    parameter int ON_TICKS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_serial_if.slave  bus
);
    localparam int DW = $clog2(DIV + 1);
    localparam int CW = $clog2(ON_TICKS + 16);
    localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {LOAD, SHIFT, LATCH, ON} state_t;

    state_t            r_state, w_state;
    logic [DW-1:0]     r_div;
    logic              w_tick;
    logic [CW-1:0]     r_cnt, w_cnt;
    logic [IW-1:0]     r_idx, w_idx;
    logic [7:0]        r_sr, w_sr;
    logic              r_sclk, w_sclk, r_sdata, w_sdata, r_latch, w_latch, r_frame, w_frame;
    logic [NDIG-1:0]   r_sel, w_sel;
    logic [4*NDIG-1:0] w_upper;
    logic [3:0]        w_val;
    logic              w_blank;
    logic [7:0]        w_glyph;

    function automatic logic [7:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    assign w_tick  = r_div == DW'(DIV - 1);
    assign w_upper = bus.digits >> (4 * r_idx);
    assign w_val   = w_upper[3:0];
    assign w_blank = (w_val > 4'd9 && !bus.hex_en) || (bus.lz_blank && r_idx != '0 && w_upper == '0);
    assign w_glyph = (w_blank ? 8'hFF : seg7(w_val)) & ~{bus.dp_mask[r_idx], 7'b0};

    assign bus.sclk       = r_sclk;
    assign bus.sdata      = r_sdata;
    assign bus.latch      = r_latch;
    assign bus.dig_sel    = r_sel;
    assign bus.frame_done = r_frame;

    // free-running divider producing the scan tick
    always_ff @(posedge clk) begin
        if (!rst_n) r_div <= '0;
        else        r_div <= w_tick ? '0 : r_div + 1'b1;
    end

    // next state and outputs; everything advances only on a tick
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_sr    = r_sr;
        w_sclk  = r_sclk;
        w_sdata = r_sdata;
        w_latch = r_latch;
        w_sel   = r_sel;
        w_frame = 1'b0;
        if (w_tick) begin
            case (r_state)
                LOAD: begin
                    w_state = SHIFT;
                    w_cnt   = '0;
                    w_sclk  = 1'b0;
                    w_sdata = w_glyph[7];
                    w_sr    = {w_glyph[6:0], 1'b1};
                end
                SHIFT: begin
                    w_cnt  = r_cnt + 1'b1;
                    w_sclk = !r_cnt[0];
                    if (r_cnt[0] && r_cnt != CW'(15)) begin
                        w_sdata = r_sr[7];
                        w_sr    = {r_sr[6:0], 1'b1};
                    end
                    if (r_cnt == CW'(15)) begin
                        w_state = LATCH;
                        w_latch = 1'b1;
                    end
                end
                LATCH: begin
                    w_state = ON;
                    w_cnt   = '0;
                    w_latch = 1'b0;
                    w_sel   = NDIG'(1) << r_idx;
                end
                default: begin
                    w_cnt = r_cnt + 1'b1;
                    if (r_cnt == CW'(ON_TICKS - 1)) begin
                        w_state = LOAD;
                        w_sel   = '0;
                        w_idx   = r_idx == IW'(NDIG - 1) ? '0 : r_idx + 1'b1;
                        w_frame = r_idx == IW'(NDIG - 1);
                    end
                end
            endcase
        end
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= LOAD;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_sr    <= 8'hFF;
            r_sclk  <= 1'b0;
            r_sdata <= 1'b1;
            r_latch <= 1'b0;
            r_sel   <= '0;
            r_frame <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_sr    <= w_sr;
            r_sclk  <= w_sclk;
            r_sdata <= w_sdata;
            r_latch <= w_latch;
            r_sel   <= w_sel;
            r_frame <= w_frame;
        end
    end
endmodule

// File: tb/tb_seg_scan_serial.sv
// tb_seg_scan_serial: randomized scan checked against a schedule/glyph model of the display
module tb_seg_scan_serial;
    localparam int NDIG     = 4;
    localparam int DIV      = 2;
    localparam int ON_TICKS = 64;
    localparam int P        = (18 + ON_TICKS) * DIV;
    localparam logic [7:0] TBL [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    typedef struct {
        logic [7:0] g;
        int         idx;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    ent_t q[$];

    logic [7:0]      sh = 8'h00;
    logic [7:0]      last_glyph [NDIG];
    int              nb = 0;
    int              cur_idx = 0;
    int              sel_start = 0;
    logic            sel_on = 1'b0;
    int              last_frame = 0;
    int              nframes = 0;
    logic            first_done = 1'b0;
    logic            p_sclk = 1'b0;
    logic            p_latch = 1'b0;
    logic [NDIG-1:0] p_sel = '0;

    seg_scan_serial_if #(.NDIG(NDIG)) bus ();

    seg_scan_serial #(.NDIG(NDIG), .DIV(DIV), .ON_TICKS(ON_TICKS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] exp_glyph(input logic [4*NDIG-1:0] d, input logic [NDIG-1:0] dp,
                                             input logic hex, input logic lz, input int i);
        logic [3:0] v;
        logic       blank;
        logic [7:0] g;
        v = d[4*i +: 4];
        blank = v > 4'd9 && !hex;
        if (lz && i > 0) begin
            logic z;
            z = 1'b1;
            for (int k = i; k < NDIG; k++) if (d[4*k +: 4] != 4'd0) z = 1'b0;
            blank = blank | z;
        end
        g = blank ? 8'hFF : TBL[v];
        if (dp[i]) g[7] = 1'b0;
        return g;
    endfunction

    function automatic logic [31:0] out_pack();
        return 32'({bus.sclk, bus.sdata, bus.latch, bus.dig_sel, bus.frame_done});
    endfunction

    // schedule model: a load happens every P clk starting DIV clk after reset release
    always @(posedge clk) begin
        if (!rst_n) begin
            cyc <= 0;
            q.delete();
        end else begin
            cyc <= cyc + 1;
            if (cyc + 1 >= DIV && (cyc + 1 - DIV) % P == 0)
                q.push_back(ent_t'{g: exp_glyph(bus.digits, bus.dp_mask, bus.hex_en, bus.lz_blank,
                                                ((cyc + 1 - DIV) / P) % NDIG),
                                   idx: ((cyc + 1 - DIV) / P) % NDIG});
        end
    end

    // observe the serial link and selects, comparing against the model
    always @(negedge clk) begin
        if (!rst_n) begin
            nb <= 0;
            sel_on <= 1'b0;
            last_frame <= 0;
            nframes <= 0;
            first_done <= 1'b0;
        end else begin
            if (bus.sclk != p_sclk) chk("ghost_sclk", 32'(bus.dig_sel), 0);
            if (bus.sclk && !p_sclk) begin
                sh <= {sh[6:0], bus.sdata};
                nb <= nb + 1;
                if (!first_done) begin
                    chk("first_rise", cyc, 2 * DIV);
                    first_done <= 1'b1;
                end
            end
            if (bus.latch && !p_latch) begin
                chk("nbits", nb, 8);
                nb <= 0;
                chk("ghost_latch", 32'(bus.dig_sel), 0);
                if (q.size() == 0) chk("load_q", q.size(), 1);
                else begin
                    chk("glyph", 32'(sh), 32'(q[0].g));
                    cur_idx <= q[0].idx;
                    last_glyph[q[0].idx] <= sh;
                    q.pop_front();
                end
            end
            if (bus.dig_sel != '0 && p_sel == '0) begin
                chk("dig_sel", 32'(bus.dig_sel), 1 << cur_idx);
                sel_start <= cyc;
                sel_on <= 1'b1;
            end
            if (bus.dig_sel == '0 && p_sel != '0 && sel_on) begin
                chk("dwell", cyc - sel_start, ON_TICKS * DIV);
                sel_on <= 1'b0;
            end
            if (bus.frame_done) begin
                chk("frame_per", cyc - last_frame, NDIG * P);
                chk("frame_end", 32'(p_sel), 1 << (NDIG - 1));
                last_frame <= cyc;
                nframes <= nframes + 1;
            end
        end
        p_sclk <= bus.sclk;
        p_latch <= bus.latch;
        p_sel <= bus.dig_sel;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_in();
        bus.digits   = (4*NDIG)'($urandom) >> (4 * $urandom_range(0, NDIG));
        bus.dp_mask  = NDIG'($urandom);
        bus.hex_en   = 1'($urandom);
        bus.lz_blank = 1'($urandom);
    endtask

    task automatic set_in(input logic [4*NDIG-1:0] d, input logic [NDIG-1:0] dp, input logic hex, input logic lz);
        bus.digits   = d;
        bus.dp_mask  = dp;
        bus.hex_en   = hex;
        bus.lz_blank = lz;
    endtask

    task automatic wait_sig(input string tag, input int sel, input int limit);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            step(1);
            hit = (sel == 0 && bus.latch) || (sel == 1 && bus.frame_done) || (sel == 2 && bus.dig_sel != '0);
        end
        chk({tag, "_wait"}, 32'(hit), 1);
    endtask

    task automatic restart();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic run_first(input string tag, input logic [4*NDIG-1:0] d, input logic [NDIG-1:0] dp,
                             input logic hex, input logic lz, input logic [7:0] exp);
        rst_n = 1'b0;
        step(2);
        set_in(d, dp, hex, lz);
        rst_n = 1'b1;
        wait_sig(tag, 0, 300);
        chk(tag, 32'(sh), 32'(exp));
    endtask

    localparam logic [7:0] LZ1 [NDIG] = '{8'hC0, 8'hF8, 8'hFF, 8'hFF};
    localparam logic [7:0] LZ0 [NDIG] = '{8'hC0, 8'hF8, 8'hC0, 8'hC0};

    initial begin
        int c;
        int n;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_in();
            step(1);
            chk("rst", out_pack(), 1 << (NDIG + 2));
        end
        run_first("glyph_3", 16'h0003, 4'h0, 1'b0, 1'b0, 8'hB0);
        step(1);
        wait_sig("sel0", 2, 300);
        chk("sel0", 32'(bus.dig_sel), 1);
        run_first("hex_off", 16'h000A, 4'h0, 1'b0, 1'b0, 8'hFF);
        run_first("hex_on", 16'h000A, 4'h0, 1'b1, 1'b0, 8'h88);
        run_first("hex_dp", 16'h000A, 4'h1, 1'b1, 1'b0, 8'h08);
        run_first("blank_dp", 16'h000F, 4'h1, 1'b0, 1'b0, 8'h7F);
        rst_n = 1'b0;
        step(2);
        set_in(16'h0070, 4'h0, 1'b0, 1'b1);
        rst_n = 1'b1;
        wait_sig("lz1", 1, 1000);
        for (int i = 0; i < NDIG; i++) chk("lz1", 32'(last_glyph[i]), 32'(LZ1[i]));
        rst_n = 1'b0;
        step(2);
        set_in(16'h0070, 4'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        wait_sig("lz0", 1, 1000);
        for (int i = 0; i < NDIG; i++) chk("lz0", 32'(last_glyph[i]), 32'(LZ0[i]));
        rand_in();
        restart();
        c = 0;
        while (nframes < 3 && c < 2500) begin
            rand_in();
            n = $urandom_range(10, 40);
            step(n);
            c += n;
        end
        chk("frames", nframes, 3);
        rand_in();
        restart();
        step(6 * DIV);
        rand_in();
        step(2);
        rst_n = 1'b0;
        step(1);
        chk("rst_mid", out_pack(), 1 << (NDIG + 2));
        rst_n = 1'b1;
        wait_sig("restart", 2, 300);
        chk("restart", 32'(bus.dig_sel), 1);
        step(400);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
